// File: rtl/cardinal_nic_fifo.sv
// Network interface between one processor port and one Cardinal router port,
// with a DEPTH-entry FIFO in each direction plus occupancy and overflow status.
module cardinal_nic_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int VC_BIT = DATA_W - 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] d_in,
   input  logic              nicEn,
   input  logic              nicEnWr,
   output logic [DATA_W-1:0] d_out,
   input  logic              net_si,
   input  logic [DATA_W-1:0] net_dl,
   output logic              net_ri,
   input  logic              net_ro,
   input  logic              net_polarity,
   output logic              net_so,
   output logic [DATA_W-1:0] net_do
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ADDR_IN_DATA    = 2'b00,
      ADDR_IN_STATUS  = 2'b01,
      ADDR_OUT_DATA   = 2'b10,
      ADDR_OUT_STATUS = 2'b11
   } addr_e;

   addr_e addr_sel;
   assign addr_sel = addr_e'(addr);

   // Eject (router -> processor) FIFO
   logic [DATA_W-1:0] in_mem [DEPTH];
   logic [PTR_W-1:0]  in_wr_ptr, in_rd_ptr;
   logic [CNT_W-1:0]  in_count;
   logic              in_empty, in_full, in_push, in_pop;

   // Inject (processor -> router) FIFO
   logic [DATA_W-1:0] out_mem [DEPTH];
   logic [PTR_W-1:0]  out_wr_ptr, out_rd_ptr;
   logic [CNT_W-1:0]  out_count;
   logic              out_empty, out_full, out_push, out_pop;
   logic [DATA_W-1:0] out_head;

   logic              ovf;
   logic              proc_rd, proc_wr, out_wr_req, ovf_set;
   logic [DATA_W-1:0] in_status, out_status;

   assign proc_rd = nicEn && !nicEnWr;
   assign proc_wr = nicEn && nicEnWr;

   assign in_empty = (in_count == '0);
   assign in_full  = (in_count == FULL_CNT);
   assign net_ri   = !in_full;
   assign in_push  = net_si && !in_full;
   assign in_pop   = proc_rd && (addr_sel == ADDR_IN_DATA) && !in_empty;

   // Full checks use the pre-pop count, so a full FIFO refuses a push even while popping.
   assign out_empty  = (out_count == '0);
   assign out_full   = (out_count == FULL_CNT);
   assign out_wr_req = proc_wr && (addr_sel == ADDR_OUT_DATA);
   assign out_push   = out_wr_req && !out_full;
   assign ovf_set    = out_wr_req && out_full;
   assign out_head   = out_mem[out_rd_ptr];
   assign out_pop    = !out_empty && net_ro && (out_head[VC_BIT] == net_polarity);

   always_comb begin
      // NOTE: every bit gets a default before the partial overrides, so no latch is inferred.
      in_status                = '0;
      in_status[DATA_W-1]      = !in_empty;
      in_status[CNT_W-1:0]     = in_count;
      out_status               = '0;
      out_status[DATA_W-1]     = out_full;
      out_status[DATA_W-2]     = ovf;
      out_status[CNT_W-1:0]    = out_count;
   end

   // NOTE: storage arrays carry no reset; the pointers and counts alone define validity.
   always_ff @(posedge clk) begin
      if (in_push)  in_mem[in_wr_ptr]   <= net_dl;
      if (out_push) out_mem[out_wr_ptr] <= d_in;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_wr_ptr  <= '0;
         in_rd_ptr  <= '0;
         in_count   <= '0;
         out_wr_ptr <= '0;
         out_rd_ptr <= '0;
         out_count  <= '0;
      end else begin
         if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
         if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
         case ({in_push, in_pop})
            2'b10:   in_count <= in_count + CNT_W'(1);
            2'b01:   in_count <= in_count - CNT_W'(1);
            default: in_count <= in_count;
         endcase

         if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
         if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
         case ({out_push, out_pop})
            2'b10:   out_count <= out_count + CNT_W'(1);
            2'b01:   out_count <= out_count - CNT_W'(1);
            default: out_count <= out_count;
         endcase
      end
   end

   // Processor read port and sticky overflow; a set wins over the read-clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_out <= '0;
         ovf   <= 1'b0;
      end else begin
         if (proc_rd) begin
            unique case (addr_sel)
               ADDR_IN_DATA:    d_out <= in_empty ? '0 : in_mem[in_rd_ptr];
               ADDR_IN_STATUS:  d_out <= in_status;
               ADDR_OUT_DATA:   d_out <= '0;
               ADDR_OUT_STATUS: d_out <= out_status;
            endcase
         end
         if (ovf_set)
            ovf <= 1'b1;
         else if (proc_rd && addr_sel == ADDR_OUT_STATUS)
            ovf <= 1'b0;
      end
   end

   // Router send side: one-cycle valid pulse, data held between packets.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         net_so <= 1'b0;
         net_do <= '0;
      end else if (out_pop) begin
         net_so <= 1'b1;
         net_do <= out_head;
      end else begin
         net_so <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Directed bench for cardinal_nic_fifo (DATA_W=64, DEPTH=4): reset, eject fill,
// inject polarity gating, overflow, same-cycle push/pop and reset mid-operation.
module tb_cardinal_nic_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic [63:0] d_in;
   logic        nicEn, nicEnWr;
   logic [63:0] d_out;
   logic        net_si;
   logic [63:0] net_dl;
   logic        net_ri;
   logic        net_ro, net_polarity;
   logic        net_so;
   logic [63:0] net_do;

   int checks = 0;
   int errors = 0;

   cardinal_nic_fifo #(.DATA_W(64), .DEPTH(4), .VC_BIT(63)) dut (
      .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .nicEn(nicEn),
      .nicEnWr(nicEnWr), .d_out(d_out), .net_si(net_si), .net_dl(net_dl),
      .net_ri(net_ri), .net_ro(net_ro), .net_polarity(net_polarity),
      .net_so(net_so), .net_do(net_do)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic proc_read(input logic [1:0] a);
      @(negedge clk);
      addr = a; nicEn = 1'b1; nicEnWr = 1'b0;
      tick();
      nicEn = 1'b0;
   endtask

   task automatic proc_write(input logic [63:0] d);
      @(negedge clk);
      addr = 2'b10; d_in = d; nicEn = 1'b1; nicEnWr = 1'b1;
      tick();
      nicEn = 1'b0; nicEnWr = 1'b0;
   endtask

   task automatic eject(input logic [63:0] d);
      @(negedge clk);
      net_si = 1'b1; net_dl = d;
      tick();
      net_si = 1'b0;
   endtask

   initial begin
      reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicEnWr = 1'b0;
      net_si = 1'b0; net_dl = '0; net_ro = 1'b0; net_polarity = 1'b0;

      // T1 reset
      repeat (5) @(posedge clk);
      #1;
      check("t1_ri_in_reset", 64'(net_ri), 64'd1);
      check("t1_so_in_reset", 64'(net_so), 64'd0);
      check("t1_dout_in_reset", d_out, 64'd0);
      @(negedge clk) reset = 1'b1;
      tick();
      check("t1_dout_after", d_out, 64'd0);
      proc_read(2'b01);
      check("t1_in_status", d_out, 64'd0);

      // T2 eject fill and drain
      for (int i = 1; i <= 4; i++) eject(64'(i));
      check("t2_ri_full", 64'(net_ri), 64'd0);
      eject(64'd5);
      check("t2_ri_still_full", 64'(net_ri), 64'd0);
      proc_read(2'b01);
      check("t2_in_status", d_out, 64'h8000_0000_0000_0004);
      proc_read(2'b00);
      check("t2_pop1", d_out, 64'd1);
      check("t2_ri_after_pop", 64'(net_ri), 64'd1);
      for (int i = 2; i <= 4; i++) begin
         proc_read(2'b00);
         check($sformatf("t2_pop%0d", i), d_out, 64'(i));
      end
      proc_read(2'b00);
      check("t2_pop_empty", d_out, 64'd0);
      proc_read(2'b10);
      check("t2_read_addr10", d_out, 64'd0);

      // T3 inject polarity gating
      @(negedge clk) begin net_ro = 1'b1; net_polarity = 1'b0; end
      proc_write(64'h8000_0000_0000_0002);
      tick();
      check("t3_no_send_a", 64'(net_so), 64'd0);
      tick();
      check("t3_no_send_b", 64'(net_so), 64'd0);
      proc_read(2'b11);
      check("t3_out_status", d_out, 64'h0000_0000_0000_0001);
      @(negedge clk) net_polarity = 1'b1;
      tick();
      check("t3_send", 64'(net_so), 64'd1);
      check("t3_send_data", net_do, 64'h8000_0000_0000_0002);
      tick();
      check("t3_pulse_end", 64'(net_so), 64'd0);
      check("t3_data_hold", net_do, 64'h8000_0000_0000_0002);

      // T4 overflow
      @(negedge clk) begin net_ro = 1'b0; net_polarity = 1'b0; end
      proc_write(64'h10);
      check("t4_write_keeps_dout", d_out, 64'h0000_0000_0000_0001);
      for (int i = 1; i <= 4; i++) proc_write(64'(16 + i));
      proc_read(2'b11);
      check("t4_status_ovf", d_out, 64'hC000_0000_0000_0004);
      proc_read(2'b11);
      check("t4_status_clr", d_out, 64'h8000_0000_0000_0004);
      @(negedge clk) net_ro = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t4_drain_so%0d", i), 64'(net_so), 64'd1);
         check($sformatf("t4_drain_do%0d", i), net_do, 64'(16 + i));
      end
      tick();
      check("t4_dropped_not_sent", 64'(net_so), 64'd0);
      @(negedge clk) net_ro = 1'b0;

      // T5 concurrency on the eject FIFO
      for (int i = 1; i <= 4; i++) eject(64'(32 + i));
      @(negedge clk) begin
         net_si = 1'b1; net_dl = 64'h99; addr = 2'b00; nicEn = 1'b1; nicEnWr = 1'b0;
      end
      tick();
      net_si = 1'b0; nicEn = 1'b0;
      check("t5_pop_on_full", d_out, 64'h21);
      proc_read(2'b01);
      check("t5_in_status", d_out, 64'h8000_0000_0000_0003);
      for (int i = 2; i <= 4; i++) begin
         proc_read(2'b00);
         check($sformatf("t5_pop%0d", i), d_out, 64'(32 + i));
      end
      proc_read(2'b00);
      check("t5_push_refused", d_out, 64'd0);

      // T5 concurrency on the inject FIFO
      proc_write(64'h31);
      proc_write(64'h32);
      @(negedge clk) begin
         net_ro = 1'b1; addr = 2'b10; d_in = 64'h33; nicEn = 1'b1; nicEnWr = 1'b1;
      end
      tick();
      net_ro = 1'b0; nicEn = 1'b0; nicEnWr = 1'b0;
      check("t5_send_so", 64'(net_so), 64'd1);
      check("t5_send_do", net_do, 64'h31);
      proc_read(2'b11);
      check("t5_out_status", d_out, 64'h0000_0000_0000_0002);

      // T6 reset mid-operation
      proc_write(64'h34);
      proc_write(64'h35);
      proc_write(64'h36);
      for (int i = 1; i <= 4; i++) eject(64'(64 + i));
      check("t6_ri_full", 64'(net_ri), 64'd0);
      @(negedge clk) net_ro = 1'b1;
      tick();
      check("t6_send_before", 64'(net_so), 64'd1);
      check("t6_send_data", net_do, 64'h32);
      #1 reset = 1'b0;
      #1;
      check("t6_ri_async", 64'(net_ri), 64'd1);
      check("t6_so_async", 64'(net_so), 64'd0);
      check("t6_do_async", net_do, 64'd0);
      check("t6_dout_async", d_out, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      tick();
      check("t6_no_send_after", 64'(net_so), 64'd0);
      proc_read(2'b11);
      check("t6_out_status", d_out, 64'd0);
      proc_read(2'b01);
      check("t6_in_status", d_out, 64'd0);
      proc_read(2'b00);
      check("t6_in_empty", d_out, 64'd0);
      check("t6_still_no_send", 64'(net_so), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
